round_sequencer: RTL and testbench

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/round_pkg.sv | 19 +
 rtl/round_counter.sv | 39 +++
 rtl/round_sequencer.sv | 126 ++++++++++++
 tb/tb_round_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_pkg.sv
// rtl/round_pkg.sv - shared types and defaults for the round sequencer
//
// Purpose: FSM state encoding and the default round-counter width used by
//          round_sequencer and round_counter.
// Ports:   none (package).

package round_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    WAIT,
    FINISH
  } state_t;

endpackage

// File: rtl/round_counter.sv
// rtl/round_counter.sv - remaining-round down counter with saturation at zero
//
// Purpose: holds the number of rounds still to run.
// Ports:   clk, rst (async, active-low)
//          load / load_val : overwrite the count (has priority over dec)
//          dec             : decrement by one, saturating at zero
//          count           : current remaining count
//          zero            : count == 0

module round_counter
  import round_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - round control FSM for an iterative cipher datapath
//
// Purpose: sequences LOAD -> (ROUND -> WAIT) x num_rounds -> FINISH.
// Ports:   clk, rst (async, active-low)
//          start, num_rounds : begin a run (sampled in IDLE only)
//          round_ack         : datapath finished the current round (WAIT only)
//          abort             : cancel the run from LOAD/ROUND/WAIT
//          load, round_en    : one-cycle datapath strobes
//          round_idx         : 0-based index of the current round
//          final_round       : current round is the last one
//          busy, done, err   : status; done/err are one-cycle pulses

module round_sequencer
  import round_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_rounds,
  input  logic             round_ack,
  input  logic             abort,
  output logic             load,
  output logic             round_en,
  output logic [CNT_W-1:0] round_idx,
  output logic             final_round,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] num_q;
  logic             err_q;

  logic             ctr_load;
  logic [CNT_W-1:0] ctr_val;
  logic             ctr_dec;
  logic [CNT_W-1:0] rem;
  logic             rem_zero;
  logic             accept;
  logic             adv_idx;

  round_counter #(.W(CNT_W)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_val),
    .dec      (ctr_dec),
    .count    (rem),
    .zero     (rem_zero)
  );

  assign accept = (state_q == IDLE) && start && (num_rounds != '0);

  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_val  = '0;
    ctr_dec  = 1'b0;
    adv_idx  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = LOAD;
          ctr_load = 1'b1;
          ctr_val  = num_rounds;
        end
      end
      LOAD:  state_d = abort ? IDLE : ROUND;
      ROUND: state_d = abort ? IDLE : WAIT;
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (round_ack) begin
          ctr_dec = 1'b1;
          // More than one round left: go again. A zero count cannot occur
          // here, but finishing is the safe way out if it ever did.
          if (!rem_zero && (rem != CNT_W'(1))) begin
            state_d = ROUND;
            adv_idx = 1'b1;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A cancelled run leaves no stale remaining count behind.
    if (abort && (state_q == LOAD || state_q == ROUND || state_q == WAIT)) begin
      ctr_load = 1'b1;
      ctr_val  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && start && (num_rounds == '0);
      if (accept) begin
        idx_q <= '0;
        num_q <= num_rounds;
      end else if (adv_idx && (idx_q != num_q - 1'b1)) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Every output is a decode of registered state.
  assign load        = (state_q == LOAD);
  assign round_en    = (state_q == ROUND);
  assign done        = (state_q == FINISH);
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign round_idx   = idx_q;
  assign final_round = busy && (idx_q == num_q - 1'b1);

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - directed self-checking bench for round_sequencer

module tb_round_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] num_rounds = '0;
  logic         round_ack = 1'b0;
  logic         abort = 1'b0;
  logic         load, round_en, final_round, busy, done, err;
  logic [W-1:0] round_idx;

  int compared = 0;
  int mismatched = 0;

  round_sequencer #(.CNT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_rounds  (num_rounds),
    .round_ack   (round_ack),
    .abort       (abort),
    .load        (load),
    .round_en    (round_en),
    .round_idx   (round_idx),
    .final_round (final_round),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  logic [W+5:0] outs;
  assign outs = {load, round_en, final_round, busy, done, err, round_idx};

  function automatic logic [W+5:0] pack(input logic l, input logic r, input logic f,
                                        input logic b, input logic d, input logic e,
                                        input logic [W-1:0] idx);
    return {l, r, f, b, d, e, idx};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    compared++;
    if (outs !== pack(0, 0, 0, 0, 0, 0, 0)) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b expected %b", outs, pack(0, 0, 0, 0, 0, 0, 0));
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_three_rounds();
    logic [W+5:0] exp;
    num_rounds = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    compared++;
    if (outs !== pack(1, 0, 0, 1, 0, 0, 0)) begin
      mismatched++;
      $display("FAIL three_load: got %b expected %b", outs, pack(1, 0, 0, 1, 0, 0, 0));
    end
    step();
    for (int r = 0; r < 3; r++) begin
      exp = pack(0, 1, (r == 2), 1, 0, 0, W'(r));
      compared++;
      if (outs !== exp) begin
        mismatched++;
        $display("FAIL three_round_en idx%0d: got %b expected %b", r, outs, exp);
      end
      step();
      exp = pack(0, 0, (r == 2), 1, 0, 0, W'(r));
      compared++;
      if (outs !== exp) begin
        mismatched++;
        $display("FAIL three_wait idx%0d: got %b expected %b", r, outs, exp);
      end
      step();
      round_ack = 1'b1;
      step();
      round_ack = 1'b0;
    end
    compared++;
    if (outs !== pack(0, 0, 1, 1, 1, 0, 2)) begin
      mismatched++;
      $display("FAIL three_done: got %b expected %b", outs, pack(0, 0, 1, 1, 1, 0, 2));
    end
    step();
    compared++;
    if (outs[W+5:W] !== 6'b0) begin
      mismatched++;
      $display("FAIL three_idle: got %b expected 000000", outs[W+5:W]);
    end
  endtask

  task automatic test_zero_rounds();
    num_rounds = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    compared++;
    if (outs[W+5:W] !== 6'b000001) begin
      mismatched++;
      $display("FAIL zero_err_pulse: got %b expected 000001", outs[W+5:W]);
    end
    step();
    compared++;
    if (outs[W+5:W] !== 6'b0) begin
      mismatched++;
      $display("FAIL zero_err_clear: got %b expected 000000", outs[W+5:W]);
    end
  endtask

  task automatic test_abort();
    logic seen;
    num_rounds = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    round_ack = 1'b1;
    step();
    round_ack = 1'b0;
    compared++;
    if (outs !== pack(0, 1, 0, 1, 0, 0, 1)) begin
      mismatched++;
      $display("FAIL abort_round1: got %b expected %b", outs, pack(0, 1, 0, 1, 0, 0, 1));
    end
    step();
    round_ack = 1'b1;
    abort = 1'b1;
    step();
    round_ack = 1'b0;
    abort = 1'b0;
    compared++;
    if (outs[W+5:W] !== 6'b0) begin
      mismatched++;
      $display("FAIL abort_idle: got %b expected 000000", outs[W+5:W]);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | load | round_en | done | busy;
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_quiet: got activity %b expected 0", seen);
    end
  endtask

  task automatic test_fifteen();
    int n, dones, cyc;
    logic bad_idx;
    num_rounds = 4'd15;
    round_ack = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    dones = 0;
    bad_idx = 1'b0;
    cyc = 0;
    while (busy && cyc < 60) begin
      step();
      cyc++;
      if (round_en) begin
        if (round_idx !== W'(n)) bad_idx = 1'b1;
        if (final_round !== (n == 14)) bad_idx = 1'b1;
        n++;
      end
      if (done) begin
        dones++;
        if (round_idx !== 4'd14) bad_idx = 1'b1;
      end
    end
    round_ack = 1'b0;
    compared++;
    if (busy !== 1'b0 || cyc !== 32) begin
      mismatched++;
      $display("FAIL fifteen_length: busy %b after %0d cycles, expected idle after 32", busy, cyc);
    end
    compared++;
    if (n !== 15 || dones !== 1) begin
      mismatched++;
      $display("FAIL fifteen_counts: got %0d rounds %0d done, expected 15 rounds 1 done", n, dones);
    end
    compared++;
    if (bad_idx !== 1'b0) begin
      mismatched++;
      $display("FAIL fifteen_idx: index/final_round sequence wrong, got flag %b expected 0", bad_idx);
    end
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    num_rounds = 4'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    round_ack = 1'b1;
    step();
    round_ack = 1'b0;
    step();
    round_ack = 1'b1;
    step();
    round_ack = 1'b0;
    step();
    compared++;
    if (outs !== pack(0, 0, 0, 1, 0, 0, 2)) begin
      mismatched++;
      $display("FAIL rstmid_wait2: got %b expected %b", outs, pack(0, 0, 0, 1, 0, 0, 2));
    end
    #2 rst = 1'b0;
    #1;
    compared++;
    if (outs !== pack(0, 0, 0, 0, 0, 0, 0)) begin
      mismatched++;
      $display("FAIL rstmid_async: got %b expected %b", outs, pack(0, 0, 0, 0, 0, 0, 0));
    end
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | done | busy | round_en;
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_quiet: got activity %b expected 0", seen);
    end
    num_rounds = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    compared++;
    if (outs !== pack(1, 0, 1, 1, 0, 0, 0)) begin
      mismatched++;
      $display("FAIL rstmid_load: got %b expected %b", outs, pack(1, 0, 1, 1, 0, 0, 0));
    end
    step();
    compared++;
    if (outs !== pack(0, 1, 1, 1, 0, 0, 0)) begin
      mismatched++;
      $display("FAIL rstmid_round: got %b expected %b", outs, pack(0, 1, 1, 1, 0, 0, 0));
    end
    step();
    round_ack = 1'b1;
    step();
    round_ack = 1'b0;
    compared++;
    if (outs !== pack(0, 0, 1, 1, 1, 0, 0)) begin
      mismatched++;
      $display("FAIL rstmid_done: got %b expected %b", outs, pack(0, 0, 1, 1, 1, 0, 0));
    end
    step();
  endtask

  task automatic test_busy_ignore();
    int n, dones, cyc;
    logic bad;
    num_rounds = 4'd2;
    start = 1'b1;
    step();
    num_rounds = 4'd7;
    round_ack = 1'b1;
    n = 0;
    dones = 0;
    bad = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      if (done) start = 1'b0;
      step();
      cyc++;
      if (round_en) begin
        if (round_idx !== W'(n) || final_round !== (n == 1)) bad = 1'b1;
        n++;
      end
      if (done) dones++;
    end
    start = 1'b0;
    round_ack = 1'b0;
    compared++;
    if (n !== 2 || dones !== 1) begin
      mismatched++;
      $display("FAIL busy_ignore_counts: got %0d rounds %0d done, expected 2 rounds 1 done", n, dones);
    end
    compared++;
    if (bad !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_ignore_seq: got bad %b busy %b, expected 0 0", bad, busy);
    end
  endtask

  initial begin
    test_reset();
    test_three_rounds();
    test_zero_rounds();
    test_abort();
    test_fifteen();
    test_reset_mid_run();
    test_busy_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
